// File: rtl/sd_fifo_ctl_2p.sv
// FIFO controller in front of a two-port memory with registered read address.
// A 2-entry output buffer absorbs the one-cycle read latency so the FIFO streams at full rate.
module sd_fifo_ctl_2p #(
    parameter int width   = 8,
    parameter int depth   = 256,
    parameter int addr_sz = $clog2(depth)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 c_srdy,
    output logic                 c_drdy,
    input  logic [width-1:0]     c_data,
    output logic                 p_srdy,
    input  logic                 p_drdy,
    output logic [width-1:0]     p_data,
    output logic [addr_sz+1:0]   usage,
    output logic                 mem_wr_en,
    output logic [addr_sz-1:0]   mem_wr_addr,
    output logic [width-1:0]     mem_d_in,
    output logic                 mem_rd_en,
    output logic [addr_sz-1:0]   mem_rd_addr,
    input  logic [width-1:0]     mem_d_out
);

    localparam logic [addr_sz:0]   DEPTH_C  = (addr_sz+1)'(depth);
    localparam logic [addr_sz-1:0] LAST_PTR = addr_sz'(depth - 1);

    logic [addr_sz-1:0]       wr_ptr_q, wr_ptr_d;
    logic [addr_sz-1:0]       rd_ptr_q, rd_ptr_d;
    logic [addr_sz:0]         mem_used_q, mem_used_d;
    logic                     inflight_q, inflight_d;
    logic [1:0]               out_cnt_q, out_cnt_d;
    logic [1:0][width-1:0]    obuf_q, obuf_d;

    logic push, pop, issue;

    always_comb begin
        c_drdy = reset_n && (mem_used_q != DEPTH_C);
        p_srdy = reset_n && (out_cnt_q != 2'd0);
        push   = c_srdy && c_drdy;
        pop    = p_srdy && p_drdy;
        // Inflight words still count in mem_used, so exclude them from what is left to read,
        // and reserve a buffer slot for them.
        issue  = reset_n
                 && (mem_used_q > (addr_sz+1)'(inflight_q))
                 && (({1'b0, out_cnt_q} + {2'b0, inflight_q}) < (3'd2 + {2'b0, pop}));

        wr_ptr_d = wr_ptr_q;
        if (push)
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;

        rd_ptr_d = rd_ptr_q;
        if (issue)
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;

        mem_used_d = mem_used_q;
        case ({push, inflight_q})
            2'b10:   mem_used_d = mem_used_q + 1'b1;
            2'b01:   mem_used_d = mem_used_q - 1'b1;
            default: mem_used_d = mem_used_q;
        endcase

        inflight_d = issue;

        obuf_d    = obuf_q;
        out_cnt_d = out_cnt_q;
        if (pop) begin
            obuf_d[0] = obuf_q[1];
            out_cnt_d = out_cnt_q - 1'b1;
        end
        // After a pop at most one entry remains, so the tail index is out_cnt_d[0].
        if (inflight_q) begin
            obuf_d[out_cnt_d[0]] = mem_d_out;
            out_cnt_d            = out_cnt_d + 1'b1;
        end

        mem_wr_en   = push;
        mem_wr_addr = wr_ptr_q;
        mem_d_in    = c_data;
        mem_rd_en   = issue;
        mem_rd_addr = rd_ptr_q;
        p_data      = obuf_q[0];
        usage       = (addr_sz+2)'(mem_used_q) + (addr_sz+2)'(out_cnt_q);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            mem_used_q <= '0;
            inflight_q <= 1'b0;
            out_cnt_q  <= '0;
            obuf_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            mem_used_q <= mem_used_d;
            inflight_q <= inflight_d;
            out_cnt_q  <= out_cnt_d;
            obuf_q     <= obuf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            assert (out_cnt_q <= 2'd2);
            assert (mem_used_q <= DEPTH_C);
            assert (!inflight_q || ((out_cnt_q - {1'b0, pop}) <= 2'd1));
        end
    end

endmodule

// File: tb/tb_sd_fifo_ctl_2p.sv
// Randomized bench: three controllers (depth 4, 5, 256) each with a small memory model,
// checked against a queue-based FIFO reference.
module tb_sd_fifo_ctl_2p;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset_n;
    logic [2:0]           c_srdy, c_drdy, p_srdy, p_drdy, mem_wr_en, mem_rd_en;
    logic [2:0][7:0]      c_data, p_data, mem_d_in;
    logic [2:0][9:0]      usage, wr_addr, rd_addr;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int D  = (g == 0) ? 4 : (g == 1) ? 5 : 256;
        localparam int AS = $clog2(D);
        logic [AS+1:0] u;
        logic [AS-1:0] wa, ra;
        logic [7:0]    dout;
        logic [7:0]    mem [2**AS];

        sd_fifo_ctl_2p #(.width(8), .depth(D)) dut (
            .clk(clk), .reset_n(reset_n),
            .c_srdy(c_srdy[g]), .c_drdy(c_drdy[g]), .c_data(c_data[g]),
            .p_srdy(p_srdy[g]), .p_drdy(p_drdy[g]), .p_data(p_data[g]),
            .usage(u),
            .mem_wr_en(mem_wr_en[g]), .mem_wr_addr(wa), .mem_d_in(mem_d_in[g]),
            .mem_rd_en(mem_rd_en[g]), .mem_rd_addr(ra), .mem_d_out(dout)
        );

        assign usage[g]   = 10'(u);
        assign wr_addr[g] = 10'(wa);
        assign rd_addr[g] = 10'(ra);

        always @(posedge clk) begin
            if (mem_wr_en[g]) mem[wa] <= mem_d_in[g];
            if (mem_rd_en[g]) dout <= mem[ra];
        end
    end

    int n_chk = 0, n_err = 0;
    int cyc = 0;
    logic [7:0] exp_q[$];
    int wr_cnt, rd_cnt, pop_cnt;
    bit hold_v;
    logic [7:0] hold_d;
    bit last_acc, last_pop, last_rd_en, last_c_drdy, last_p_srdy;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int dep(input int s);
        return (s == 0) ? 4 : (s == 1) ? 5 : 256;
    endfunction

    task automatic clr_model();
        exp_q.delete();
        wr_cnt = 0; rd_cnt = 0; pop_cnt = 0; hold_v = 0; hold_d = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; c_srdy = '0; p_drdy = '0; c_data = '0;
        #1;
        check("rst_c_drdy", c_drdy, 0);
        check("rst_p_srdy", p_srdy, 0);
        check("rst_wr_en", mem_wr_en, 0);
        check("rst_rd_en", mem_rd_en, 0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        clr_model();
        #1;
        check("post_rst_c_drdy", c_drdy, 3'b111);
        check("post_rst_p_srdy", p_srdy, 0);
        check("post_rst_rd_en", mem_rd_en, 0);
        for (int i = 0; i < 3; i++) begin
            check("post_rst_usage", usage[i], 0);
            check("post_rst_p_data", p_data[i], 0);
        end
    endtask

    // One clock on instance s: drive at negedge, check settled outputs, then update model.
    task automatic cycle(input int s, input bit cs, input logic [7:0] cd, input bit pd);
        @(negedge clk);
        c_srdy[s] = cs; c_data[s] = cd; p_drdy[s] = pd;
        #1;
        cyc++;
        last_acc    = c_srdy[s] & c_drdy[s];
        last_pop    = p_srdy[s] & p_drdy[s];
        last_rd_en  = mem_rd_en[s];
        last_c_drdy = c_drdy[s];
        last_p_srdy = p_srdy[s];
        check("wr_en", mem_wr_en[s], last_acc);
        if (last_acc) begin
            check("wr_addr", wr_addr[s], wr_cnt % dep(s));
            check("d_in", mem_d_in[s], cd);
        end
        if (mem_rd_en[s]) begin
            check("rd_before_wr", int'(rd_cnt < wr_cnt), 1);
            check("rd_addr", rd_addr[s], rd_cnt % dep(s));
            rd_cnt++;
        end
        if (hold_v) begin
            check("hold_srdy", p_srdy[s], 1);
            check("hold_data", p_data[s], hold_d);
        end
        if (exp_q.size() == 0) check("empty_srdy", p_srdy[s], 0);
        if (last_pop) begin
            if (exp_q.size() == 0) check("spurious_pop", last_pop, 0);
            else check("p_data", p_data[s], exp_q.pop_front());
            pop_cnt++;
        end
        hold_v = p_srdy[s] & ~p_drdy[s];
        hold_d = p_data[s];
        if (last_acc) begin
            exp_q.push_back(cd);
            wr_cnt++;
        end
        @(posedge clk);
        #1;
        check("usage", usage[s], exp_q.size());
    endtask

    task automatic rand_run(input int s, input int nwords, input int bound);
        int sent = 0, t = 0;
        bit cs;
        logic [7:0] d;
        while ((sent < nwords || exp_q.size() != 0) && t < bound) begin
            cs = (sent < nwords) && ($urandom_range(0, 3) != 0);
            d  = 8'($urandom);
            cycle(s, cs, d, $urandom_range(0, 2) != 0);
            if (last_acc) sent++;
            t++;
        end
        check("rand_done_in_bound", int'(t < bound), 1);
        check("rand_sent", sent, nwords);
        check("rand_wr_cnt", wr_cnt, nwords);
    endtask

    initial begin
        int first_pop, last_pop_cyc, t, acc;
        reset_n = 1'b0; c_srdy = '0; p_drdy = '0; c_data = '0;

        do_reset();

        // single word: read issued next cycle, visible two edges after acceptance
        cycle(2, 1, 8'h5A, 1);
        check("single_acc", last_acc, 1);
        cycle(2, 0, 0, 1);
        check("single_rd_en", last_rd_en, 1);
        cycle(2, 0, 0, 1);
        check("single_srdy_early", last_p_srdy, 0);
        cycle(2, 0, 0, 1);
        check("single_srdy", last_p_srdy, 1);
        check("single_pop", last_pop, 1);
        check("single_usage", usage[2], 0);

        // streaming 0x00..0xFF at full rate
        do_reset();
        first_pop = -1; last_pop_cyc = -1;
        t = cyc;
        for (int i = 0; i < 256; i++) begin
            cycle(2, 1, 8'(i), 1);
            if (last_pop) begin
                if (first_pop < 0) first_pop = cyc;
                last_pop_cyc = cyc;
            end
        end
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            cycle(2, 0, 0, 1);
            if (last_pop) last_pop_cyc = cyc;
        end
        check("stream_pops", pop_cnt, 256);
        check("stream_latency", first_pop - (t + 1), 3);
        check("stream_no_bubble", last_pop_cyc - first_pop, 255);

        // fill depth-4 instance with output stalled
        do_reset();
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(0, 1, 8'(acc), 0);
            if (last_acc) acc++;
        end
        check("fill_acc", acc, 6);
        check("fill_drdy", c_drdy[0], 0);
        check("fill_usage", usage[0], 6);
        cycle(0, 0, 0, 1);
        check("drain_drdy0", last_c_drdy, 0);
        cycle(0, 0, 0, 1);
        check("drain_drdy1", last_c_drdy, 0);
        cycle(0, 0, 0, 1);
        check("drain_drdy2", last_c_drdy, 1);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) cycle(0, 0, 0, 1);
        check("drain_pops", pop_cnt, 6);

        // non-power-of-2 depth with random stalls, then a longer soak on depth 4
        do_reset();
        rand_run(1, 12, 600);
        do_reset();
        rand_run(0, 150, 3000);

        // reset while a read is in flight and the buffer is occupied
        do_reset();
        for (int i = 0; i < 6; i++) cycle(0, 1, 8'(i + 1), 0);
        cycle(0, 0, 0, 1);
        check("mid_issue", last_rd_en, 1);
        do_reset();
        cycle(0, 1, 8'h33, 1);
        t = 0;
        while (!last_pop && t < 8) begin
            cycle(0, 0, 0, 1);
            t++;
        end
        check("after_rst_out", int'(last_pop), 1);
        check("after_rst_pops", pop_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
